// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive frame checker.
// Holds the frame FSM states, parity type codes and counter defaults.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } rx_state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int ERR_CNT_WIDTH_DEF = 8;

endpackage

// File: rtl/uart_rx_frame_check_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
// Ports: clk, rst (sync, active-high), clr, inc, count[WIDTH-1:0].
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/uart_rx_frame_check.sv
// UART Rx frame tracker: walks start/data/parity/stop bits on bit_strobe,
// rebuilds the data word and reports start/parity/stop errors on frame_done.
// Ports: CLK, RST (sync, active-high); cfg_par_en/cfg_par_typ/cfg_stop2
// latched at frame_start; bit_strobe + sampled_bit from the sampler;
// cnt_clr clears counters. Outputs busy, frame_done, data_out, the three
// error flags and their saturating counters.
module uart_rx_frame_check
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ERR_CNT_WIDTH = ERR_CNT_WIDTH_DEF
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     cfg_par_en,
    input  logic                     cfg_par_typ,
    input  logic                     cfg_stop2,
    input  logic                     frame_start,
    input  logic                     bit_strobe,
    input  logic                     sampled_bit,
    input  logic                     cnt_clr,
    output logic                     busy,
    output logic                     frame_done,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     strt_err,
    output logic                     par_err,
    output logic                     stp_err,
    output logic [ERR_CNT_WIDTH-1:0] par_err_cnt,
    output logic [ERR_CNT_WIDTH-1:0] stp_err_cnt,
    output logic [ERR_CNT_WIDTH-1:0] strt_err_cnt
);

    localparam logic [3:0] IDX_LAST = 4'(DATA_WIDTH - 1);

    rx_state_t             state;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  stop2_q;
    logic [3:0]            bit_idx;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  acc;
    logic                  par_pend;
    logic                  stp_pend;

    logic                  par_exp;
    logic                  stp_now;
    logic                  last_data;

    assign busy      = (state != ST_IDLE);
    assign par_exp   = acc ^ (par_typ_q == PAR_ODD);
    // Stop error including the bit being sampled right now.
    assign stp_now   = stp_pend | ~sampled_bit;
    assign last_data = (bit_idx == IDX_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            stop2_q    <= 1'b0;
            bit_idx    <= '0;
            shreg      <= '0;
            acc        <= 1'b0;
            par_pend   <= 1'b0;
            stp_pend   <= 1'b0;
            frame_done <= 1'b0;
            data_out   <= '0;
            strt_err   <= 1'b0;
            par_err    <= 1'b0;
            stp_err    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        par_en_q  <= cfg_par_en;
                        par_typ_q <= cfg_par_typ;
                        stop2_q   <= cfg_stop2;
                        par_pend  <= 1'b0;
                        stp_pend  <= 1'b0;
                        state     <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_strobe) begin
                        if (sampled_bit) begin
                            // Glitch: report now, keep the old word.
                            frame_done <= 1'b1;
                            strt_err   <= 1'b1;
                            par_err    <= 1'b0;
                            stp_err    <= 1'b0;
                            state      <= ST_IDLE;
                        end else begin
                            bit_idx <= '0;
                            acc     <= 1'b0;
                            state   <= ST_DATA;
                        end
                    end
                end
                ST_DATA: begin
                    if (bit_strobe) begin
                        // LSB arrives first, so shift in from the top.
                        shreg   <= {sampled_bit, shreg[DATA_WIDTH-1:1]};
                        acc     <= acc ^ sampled_bit;
                        bit_idx <= bit_idx + 4'd1;
                        if (last_data) begin
                            state <= par_en_q ? ST_PARITY : ST_STOP1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (bit_strobe) begin
                        par_pend <= (sampled_bit != par_exp);
                        state    <= ST_STOP1;
                    end
                end
                ST_STOP1: begin
                    if (bit_strobe) begin
                        if (stop2_q) begin
                            stp_pend <= stp_now;
                            state    <= ST_STOP2;
                        end else begin
                            frame_done <= 1'b1;
                            data_out   <= shreg;
                            strt_err   <= 1'b0;
                            par_err    <= par_en_q & par_pend;
                            stp_err    <= stp_now;
                            state      <= ST_IDLE;
                        end
                    end
                end
                ST_STOP2: begin
                    if (bit_strobe) begin
                        frame_done <= 1'b1;
                        data_out   <= shreg;
                        strt_err   <= 1'b0;
                        par_err    <= par_en_q & par_pend;
                        stp_err    <= stp_now;
                        state      <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_par_cnt (
        .clk   (CLK),
        .rst   (RST),
        .clr   (cnt_clr),
        .inc   (frame_done & par_err),
        .count (par_err_cnt)
    );

    sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_stp_cnt (
        .clk   (CLK),
        .rst   (RST),
        .clr   (cnt_clr),
        .inc   (frame_done & stp_err),
        .count (stp_err_cnt)
    );

    sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_strt_cnt (
        .clk   (CLK),
        .rst   (RST),
        .clr   (cnt_clr),
        .inc   (frame_done & strt_err),
        .count (strt_err_cnt)
    );

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Randomized bench for uart_rx_frame_check against a frame-level model.
// Ports: none; drives the DUT on negedges and samples on negedges.
module tb_uart_rx_frame_check;

    localparam int DW = 8;
    localparam int CW = 8;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          cfg_par_en = 1'b0;
    logic          cfg_par_typ = 1'b0;
    logic          cfg_stop2 = 1'b0;
    logic          frame_start = 1'b0;
    logic          bit_strobe = 1'b0;
    logic          sampled_bit = 1'b1;
    logic          cnt_clr = 1'b0;
    logic          busy;
    logic          frame_done;
    logic [DW-1:0] data_out;
    logic          strt_err;
    logic          par_err;
    logic          stp_err;
    logic [CW-1:0] par_err_cnt;
    logic [CW-1:0] stp_err_cnt;
    logic [CW-1:0] strt_err_cnt;

    int checks = 0;
    int errors = 0;

    // Model state: last reported word and error counts.
    int m_data = 0;
    int m_par  = 0;
    int m_stp  = 0;
    int m_strt = 0;

    always #5 CLK = ~CLK;

    uart_rx_frame_check #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(CW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .cfg_par_en   (cfg_par_en),
        .cfg_par_typ  (cfg_par_typ),
        .cfg_stop2    (cfg_stop2),
        .frame_start  (frame_start),
        .bit_strobe   (bit_strobe),
        .sampled_bit  (sampled_bit),
        .cnt_clr      (cnt_clr),
        .busy         (busy),
        .frame_done   (frame_done),
        .data_out     (data_out),
        .strt_err     (strt_err),
        .par_err      (par_err),
        .stp_err      (stp_err),
        .par_err_cnt  (par_err_cnt),
        .stp_err_cnt  (stp_err_cnt),
        .strt_err_cnt (strt_err_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_inc(input int c, input bit f);
        if (f && c < (1 << CW) - 1) return c + 1;
        return c;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_data"}, data_out, 0);
        chk({tag, "_flags"}, {strt_err, par_err, stp_err}, 0);
        chk({tag, "_cnts"}, {par_err_cnt, stp_err_cnt, strt_err_cnt}, 0);
    endtask

    // Sends one frame; pb/s1b/s2b are the raw parity and stop line values.
    task automatic send_frame(input logic [7:0] d, input bit pe, input bit pt,
                              input bit s2, input bit sb, input bit pb,
                              input bit s1b, input bit s2b,
                              input bit clr_at_done, input bit ghost);
        bit q[$];
        bit early;
        bit e_strt, e_par, e_stp;
        int gap;
        early = 0;
        q.push_back(sb);
        if (!sb) begin
            for (int i = 0; i < DW; i++) q.push_back(d[i]);
            if (pe) q.push_back(pb);
            q.push_back(s1b);
            if (s2) q.push_back(s2b);
        end
        @(negedge CLK);
        frame_start = 1'b1;
        cfg_par_en  = pe;
        cfg_par_typ = pt;
        cfg_stop2   = s2;
        @(negedge CLK);
        frame_start = 1'b0;
        cfg_par_en  = 1'($urandom);
        cfg_par_typ = 1'($urandom);
        cfg_stop2   = 1'($urandom);
        chk("busy_after_start", busy, 1);
        for (int i = 0; i < q.size(); i++) begin
            gap = $urandom_range(0, 2);
            repeat (gap) begin
                @(negedge CLK);
                early |= frame_done;
                bit_strobe  = 1'b0;
                frame_start = 1'b0;
                sampled_bit = 1'($urandom);
            end
            @(negedge CLK);
            early |= frame_done;
            bit_strobe  = 1'b1;
            sampled_bit = q[i];
            frame_start = ghost && (i == 3);
        end
        @(negedge CLK);
        bit_strobe  = 1'b0;
        frame_start = 1'b0;
        sampled_bit = 1'($urandom);

        if (sb) begin
            e_strt = 1; e_par = 0; e_stp = 0;
        end else begin
            e_strt = 0;
            e_par  = pe && (pb != ((^d) ^ pt));
            e_stp  = !s1b || (s2 && !s2b);
            m_data = d;
        end
        chk("early_done", early, 0);
        chk("frame_done", frame_done, 1);
        chk("busy_at_done", busy, 0);
        chk("data_out", data_out, m_data);
        chk("strt_err", strt_err, e_strt);
        chk("par_err", par_err, e_par);
        chk("stp_err", stp_err, e_stp);
        if (clr_at_done) begin
            m_par = 0; m_stp = 0; m_strt = 0;
        end else begin
            m_par  = sat_inc(m_par, e_par);
            m_stp  = sat_inc(m_stp, e_stp);
            m_strt = sat_inc(m_strt, e_strt);
        end
        cnt_clr = clr_at_done;
        @(negedge CLK);
        cnt_clr = 1'b0;
        chk("done_pulse_len", frame_done, 0);
        chk("par_err_cnt", par_err_cnt, m_par);
        chk("stp_err_cnt", stp_err_cnt, m_stp);
        chk("strt_err_cnt", strt_err_cnt, m_strt);
    endtask

    // Starts a frame and resets on the strobe of data bit 4.
    task automatic reset_mid_frame(input logic [7:0] d);
        bit seen;
        seen = 0;
        @(negedge CLK);
        frame_start = 1'b1;
        cfg_par_en  = 1'b1;
        @(negedge CLK);
        frame_start = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            @(negedge CLK);
            seen |= frame_done;
            bit_strobe  = 1'b1;
            sampled_bit = (i == 0) ? 1'b0 : d[i-1];
            RST         = (i == 5);
        end
        @(negedge CLK);
        bit_strobe = 1'b0;
        RST        = 1'b0;
        seen |= frame_done;
        m_data = 0; m_par = 0; m_stp = 0; m_strt = 0;
        chk("rst_mid_no_done", seen, 0);
        check_idle_outputs("rst_mid");
    endtask

    initial begin
        logic [7:0] rd;
        bit rpe, rpt, rs2, rsb, rpb, rs1, rs2b;
        repeat (3) @(negedge CLK);
        check_idle_outputs("reset");
        RST = 1'b0;
        @(negedge CLK);
        check_idle_outputs("post_reset");

        // Clean even-parity frame.
        send_frame(8'hA5, 1, 0, 0, 0, 0, 1, 1, 0, 0);
        // Odd parity with wrong parity bit, then saturate.
        for (int i = 0; i < 256; i++)
            send_frame(8'hA5, 1, 1, 0, 0, 0, 1, 1, 0, 0);
        chk("par_sat", par_err_cnt, 8'hFF);
        // Two stops, second low.
        send_frame(8'hA5, 1, 0, 1, 0, 0, 1, 0, 0, 0);
        // Start glitch keeps previous word.
        send_frame(8'h00, 0, 0, 0, 1, 0, 1, 1, 0, 0);
        chk("strt_keep_data", data_out, 8'hA5);
        // Reset in the middle, then a clean frame.
        reset_mid_frame(8'h5A);
        send_frame(8'h3C, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        chk("after_rst_data", data_out, 8'h3C);
        // Clear coincident with a parity error, plus a ghost start.
        send_frame(8'h81, 1, 0, 0, 0, 1, 1, 1, 0, 1);
        send_frame(8'h81, 1, 0, 0, 0, 1, 1, 1, 1, 1);
        chk("clr_wins", par_err_cnt, 0);

        for (int n = 0; n < 300; n++) begin
            rd   = 8'($urandom);
            rpe  = 1'($urandom);
            rpt  = 1'($urandom);
            rs2  = 1'($urandom);
            rsb  = ($urandom_range(0, 9) == 0);
            rpb  = 1'($urandom);
            rs1  = ($urandom_range(0, 3) != 0);
            rs2b = ($urandom_range(0, 3) != 0);
            send_frame(rd, rpe, rpt, rs2, rsb, rpb, rs1, rs2b,
                       $urandom_range(0, 19) == 0, 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_check.md
Name: uart_rx_frame_check

Overview:
- Parametrised successor to the single-bit UART Rx stop checker.
- Runs its own frame tracker: start, DATA_WIDTH data bits, optional parity, then 1 or 2 stop bits.
- Checks every bit class, reassembles the data word, and reports all errors together on one frame-done pulse.
- Keeps saturating per-class error counters for the register file; sits between the Rx sampler and the Rx output stage.

Parameters:
- DATA_WIDTH, 8, number of data bits per frame (5..9).
- ERR_CNT_WIDTH, 8, width of each saturating error counter.

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous reset, active-high.
- cfg_par_en  input  1  parity bit present when 1.
- cfg_par_typ  input  1  0 = even, 1 = odd.
- cfg_stop2  input  1  two stop bits when 1, else one.
- frame_start  input  1  start edge detected; begins a frame.
- bit_strobe  input  1  one-cycle pulse: sampled_bit is valid this cycle.
- sampled_bit  input  1  majority-sampled line value.
- cnt_clr  input  1  clears all error counters.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse; data_out and flags updated.
- data_out  output  DATA_WIDTH  received word, LSB first on the line.
- strt_err  output  1  start bit sampled high (glitch).
- par_err  output  1  parity mismatch.
- stp_err  output  1  any stop bit sampled low.
- par_err_cnt  output  ERR_CNT_WIDTH  saturating parity-error count.
- stp_err_cnt  output  ERR_CNT_WIDTH  saturating stop-error count.
- strt_err_cnt  output  ERR_CNT_WIDTH  saturating start-error count.

Behaviour:
- Clocking and reset: single clock CLK; RST is synchronous and active-high.
- Reset values: every output is 0; the FSM enters IDLE. A reset mid-frame aborts with no frame_done pulse.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE:
  - frame_start=1 latches cfg_par_en, cfg_par_typ and cfg_stop2, then moves to START; busy=1 from the next cycle.
  - Config changes mid-frame are ignored.
- frame_start outside IDLE is ignored.
- States only advance on bit_strobe. Non-strobe cycles hold all state.
- START:
  - sampled_bit=0 moves to DATA, with bit index cleared and the parity accumulator cleared.
  - sampled_bit=1 ends the frame: next cycle frame_done=1, strt_err=1, par_err=0, stp_err=0, data_out unchanged. Return to IDLE.
- DATA:
  - Each strobe shifts sampled_bit into the shift register MSB-side (LSB-first reception) and XORs it into the accumulator.
  - After strobe DATA_WIDTH-1, go to PARITY if the latched par_en is set, else STOP1.
- PARITY:
  - expected = accumulator XOR par_typ.
  - Error flag pending = (sampled_bit != expected); go to STOP1.
- STOP1:
  - Pending stop error |= ~sampled_bit.
  - Go to STOP2 if the latched stop2 is set; else finish.
- STOP2:
  - Pending stop error |= ~sampled_bit; finish.
  - A STOP1 error does not skip STOP2, so frame alignment is preserved.
- Finish (one cycle after the final strobe, registered):
  - frame_done=1 for one cycle.
  - data_out is loaded from the shift register.
  - strt_err=0; par_err and stp_err take their pending values (par_err=0 when parity is disabled).
  - Return to IDLE; busy=0 in the same cycle as frame_done.
- Flag persistence: data_out and all flags hold until the next frame_done or RST.
- frame_start arriving in the frame_done cycle is accepted (the FSM is already IDLE).
- Counters:
  - On frame_done, each counter whose flag is 1 increments by 1.
  - Counters saturate at all-ones and never wrap.
  - cnt_clr zeroes all counters next cycle; cnt_clr wins over a simultaneous increment.
- Latency: frame_done occurs exactly 1 cycle after the strobe of the last frame bit.

Decomposition:
- Shared package uart_rx_pkg holds:
  - the FSM state enumeration;
  - PAR_EVEN/PAR_ODD constants;
  - the default ERR_CNT_WIDTH.
- One sub-module, sat_counter (parameter WIDTH; inputs clr, inc; clr has priority), is instantiated three times.

Test Plan:
- Even parity, 1 stop, DATA_WIDTH=8: send 0xA5, parity 0, stop 1 -> frame_done once, data_out=0xA5, all flags 0, counters 0.
- Odd parity, 0xA5, parity bit 0 -> par_err=1, par_err_cnt=1. Same frame repeated 255 times -> counter 8'hFF, then stays at 8'hFF on the next error.
- cfg_stop2=1, STOP1=1, STOP2=0 -> stp_err=1; frame_done arrives 1 cycle after the second stop strobe, not the first.
- Start bit sampled 1 -> frame_done next cycle, strt_err=1, data_out keeps its previous 0xA5, strt_err_cnt=1, busy=0.
- RST=1 during DATA bit 4 -> no frame_done, outputs 0, FSM IDLE. A following clean 0x3C frame is received correctly.
- cnt_clr asserted in the same cycle as frame_done with par_err -> par_err_cnt=0 afterwards. A frame_start pulsed mid-frame changes nothing.
